inst_mem_loader: RTL and testbench

INST_MEM_LOADER -- requirements
Module: inst_mem_loader

---
 rtl/inst_mem_loader.sv | 137 +++++++++++++
 tb/tb_inst_mem_loader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
// Streams instruction words into instruction memory, then releases the scalar core from reset.
// Optional trailer-checksum verification is enabled by defining LOADER_CHECKSUM_EN.
module inst_mem_loader #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [CNT_W-1:0]  word_count_i,
  input  logic              s_valid_i,
  input  logic [31:0]       s_data_i,
  output logic              s_ready_o,
  output logic              inst_we_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic [31:0]       instruction_o,
  output logic              core_rstn_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [1:0]        state_o
);

  // Handshake: a word transfers on a rising edge where s_valid_i & s_ready_o;
  // s_valid_i may toggle freely and s_ready_o depends only on the state register.
  // state_o encoding: 0 IDLE, 1 LOAD, 2 CHECK, 3 RUN.
`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, CHECK = 2'd2, RUN = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd3} state_t;
`endif

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  count;
  logic              hs;
  logic              start_ok;
  logic [ADDR_W-1:0] base_aligned;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]       csum;
`endif

`ifdef LOADER_CHECKSUM_EN
  assign s_ready_o = (state == LOAD) || (state == CHECK);
`else
  assign s_ready_o = (state == LOAD);
`endif
  assign busy_o       = s_ready_o;
  assign state_o      = state;
  assign hs           = s_valid_i & s_ready_o;
  assign start_ok     = start_i && (word_count_i != '0);
  assign base_aligned = {base_addr_i[ADDR_W-1:2], 2'b00};

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state         <= IDLE;
      addr          <= '0;
      count         <= '0;
      inst_we_o     <= 1'b0;
      inst_addr_o   <= '0;
      instruction_o <= '0;
      core_rstn_o   <= 1'b0;
      done_o        <= 1'b0;
      error_o       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum          <= '0;
`endif
    end else begin
      inst_we_o <= 1'b0;
      done_o    <= 1'b0;
      error_o   <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            state <= LOAD;
            addr  <= base_aligned;
            count <= word_count_i;
`ifdef LOADER_CHECKSUM_EN
            csum  <= '0;
`endif
          end else if (start_i) begin
            error_o <= 1'b1;
          end
        end
        LOAD: begin
          if (hs) begin
            inst_we_o     <= 1'b1;
            inst_addr_o   <= addr;
            instruction_o <= s_data_i;
            addr          <= addr + ADDR_W'(4);
            count         <= count - CNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
            csum          <= csum ^ s_data_i;
            if (count == CNT_W'(1)) state <= CHECK;
`else
            if (count == CNT_W'(1)) state <= RUN;
`endif
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHECK: begin
          if (hs) begin
            if (s_data_i == csum) begin
              state <= RUN;
            end else begin
              state   <= IDLE;
              error_o <= 1'b1;
            end
          end
        end
`endif
        RUN: begin
          // The core is released one cycle after entering RUN, so it never
          // overlaps the final instruction write.
          if (start_ok) begin
            state       <= LOAD;
            addr        <= base_aligned;
            count       <= word_count_i;
            core_rstn_o <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum        <= '0;
`endif
          end else begin
            if (start_i) error_o <= 1'b1;
            if (!core_rstn_o) begin
              core_rstn_o <= 1'b1;
              done_o      <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Randomized self-checking bench for inst_mem_loader: expected writes are derived
// from base address and word index, compared against observed write pulses.
`timescale 1ns/1ps
module tb_inst_mem_loader;
  localparam int ADDR_W = 16;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0]  word_count = '0;
  logic              s_valid = 1'b0;
  logic [31:0]       s_data = '0;
  logic              s_ready_o, inst_we_o, core_rstn_o, busy_o, done_o, error_o;
  logic [ADDR_W-1:0] inst_addr_o;
  logic [31:0]       instruction_o;
  logic [1:0]        state_o;

  inst_mem_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rstn_i(rstn), .start_i(start), .base_addr_i(base_addr),
    .word_count_i(word_count), .s_valid_i(s_valid), .s_data_i(s_data),
    .s_ready_o(s_ready_o), .inst_we_o(inst_we_o), .inst_addr_o(inst_addr_o),
    .instruction_o(instruction_o), .core_rstn_o(core_rstn_o), .busy_o(busy_o),
    .done_o(done_o), .error_o(error_o), .state_o(state_o)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: {addr, data} of every write the model says must happen, in order
  logic [ADDR_W+31:0] exp_q[$];
  logic [ADDR_W+31:0] mon_e;
  int                 we_cyc[$];
  int                 err_cnt = 0;

  always @(negedge clk) begin
    if (inst_we_o) begin
      if (exp_q.size() == 0) begin
        check("spurious_we", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", inst_addr_o, mon_e[ADDR_W+31:32]);
        check("wr_data", instruction_o, mon_e[31:0]);
      end
      check("core_held_during_wr", core_rstn_o, 0);
      we_cyc.push_back(cyc_n);
    end
    if (error_o) err_cnt++;
  end

  logic [31:0] dir_w[$];

  function automatic logic [ADDR_W-1:0] model_addr(input logic [ADDR_W-1:0] base, input int idx);
    logic [ADDR_W-1:0] a;
    a = base & ~ADDR_W'(3);
    return a + ADDR_W'(4 * idx);
  endfunction

  // driver: mode 0 back-to-back, 1 valid toggling, 2 random valid
  task automatic do_load(input logic [ADDR_W-1:0] base, input int n, input int mode,
                         input int abort_at, input bit bad_trailer);
    logic [31:0] x;
    logic [31:0] csum;
    int          i;
    int          cyc;
    int          w0;
    int          k;
    csum = '0;
    w0   = we_cyc.size();
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; word_count = CNT_W'(n);
    @(posedge clk); #1;
    start = 1'b0; base_addr = ADDR_W'($urandom); word_count = CNT_W'($urandom);
    check("busy_after_start", busy_o, 1);
    check("core_low_after_start", core_rstn_o, 0);
    i = 0;
    cyc = 0;
    while (i < n && cyc < 500) begin
      if (abort_at == i) break;
      case (mode)
        0:       s_valid = 1'b1;
        1:       s_valid = (cyc % 2 == 0);
        default: s_valid = 1'($urandom_range(0, 1));
      endcase
      x = (i < dir_w.size()) ? dir_w[i] : $urandom;
      s_data = x;
      @(negedge clk);
      if (s_valid && s_ready_o) begin
        exp_q.push_back({model_addr(base, i), x});
        csum ^= x;
        i++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (abort_at >= 0) begin
      rstn = 1'b0;
      s_valid = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("rst_ready", s_ready_o, 0);
      check("rst_we", inst_we_o, 0);
      check("rst_addr", inst_addr_o, 0);
      check("rst_instr", instruction_o, 0);
      check("rst_core", core_rstn_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_error", error_o, 0);
      check("rst_state", state_o, 0);
      repeat (3) @(negedge clk);
      check("abort_wr_count", we_cyc.size() - w0, abort_at - 1);
      s_valid = 1'b0;
      rstn = 1'b1;
      return;
    end
    s_valid = 1'b0;
    check("load_progress", i, n);
`ifdef LOADER_CHECKSUM_EN
    s_valid = 1'b1;
    s_data  = bad_trailer ? (csum ^ 32'h1) : csum;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (s_ready_o) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    if (bad_trailer) begin
      @(negedge clk);
      check("bad_trailer_error", error_o, 1);
      check("bad_trailer_state", state_o, 0);
      check("bad_trailer_core", core_rstn_o, 0);
      check("bad_trailer_wr_count", we_cyc.size() - w0, n);
      @(negedge clk);
      check("bad_trailer_err_pulse", error_o, 0);
      return;
    end
`else
    if (bad_trailer) check("bad_trailer_unsupported", 0, 1);
`endif
    for (k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done_o) break;
    end
    check("done_seen", k < 10, 1);
    check("core_released", core_rstn_o, 1);
    check("busy_cleared", busy_o, 0);
    check("ready_low_run", s_ready_o, 0);
    check("all_written", exp_q.size(), 0);
    check("wr_count", we_cyc.size() - w0, n);
`ifndef LOADER_CHECKSUM_EN
    if (we_cyc.size() > w0) check("done_after_last_wr", cyc_n, we_cyc[we_cyc.size()-1] + 1);
`endif
    if (mode == 0 && we_cyc.size() - w0 == n)
      check("back_to_back", we_cyc[we_cyc.size()-1] - we_cyc[w0], n - 1);
    @(negedge clk);
    check("done_one_cycle", done_o, 0);
  endtask

  task automatic zero_count();
    int w0;
    int e0;
    w0 = we_cyc.size();
    e0 = err_cnt;
    @(posedge clk); #1;
    start = 1'b1; word_count = '0; base_addr = ADDR_W'($urandom);
    @(posedge clk); #1;
    start = 1'b0;
    check("zero_error", error_o, 1);
    check("zero_state", state_o, 0);
    check("zero_core", core_rstn_o, 0);
    check("zero_busy", busy_o, 0);
    @(posedge clk); #1;
    check("zero_err_pulse", error_o, 0);
    repeat (2) @(negedge clk);
    check("zero_err_count", err_cnt - e0, 1);
    check("zero_no_write", we_cyc.size() - w0, 0);
  endtask

  initial begin
    rstn = 1'b0;
    s_valid = 1'b1;
    s_data = $urandom;
    start = 1'b1;
    word_count = 16'd5;
    repeat (3) @(negedge clk);
    check("reset_ready", s_ready_o, 0);
    check("reset_we", inst_we_o, 0);
    check("reset_addr", inst_addr_o, 0);
    check("reset_instr", instruction_o, 0);
    check("reset_core", core_rstn_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_done", done_o, 0);
    check("reset_error", error_o, 0);
    check("reset_state", state_o, 0);
    start = 1'b0;
    s_valid = 1'b0;
    rstn = 1'b1;

    zero_count();

    dir_w = '{32'hA, 32'hB, 32'hC};
    do_load(16'h0100, 3, 0, -1, 1'b0);
    dir_w.delete();

    do_load(16'hFFF8, 3, 2, -1, 1'b0);
    do_load(16'h0103, 2, 2, -1, 1'b0);
    do_load(ADDR_W'($urandom), 4, 1, -1, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    dir_w = '{32'h1, 32'h2};
    do_load(ADDR_W'($urandom), 2, 0, -1, 1'b0);
    do_load(ADDR_W'($urandom), 2, 0, -1, 1'b1);
    dir_w.delete();
`endif

    for (int j = 0; j < 8; j++)
      do_load(ADDR_W'($urandom), $urandom_range(1, 8), $urandom_range(0, 2), -1, 1'b0);

    do_load(16'h0200, 4, 0, 2, 1'b0);
    do_load(ADDR_W'($urandom), $urandom_range(1, 6), 2, -1, 1'b0);

    repeat (3) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
